// File: rtl/mult_array_pipe_if.sv
// Beat/product bundle between the distribution network, the multiplier array and the reduction network.
// The master drives operands and output-ready; the slave (the array) returns products, status and input-ready.
interface mult_array_pipe_if #(
    parameter int IN_DATA_TYPE  = 8,
    parameter int OUT_DATA_TYPE = 24,
    parameter int NUM_PES       = 32,
    parameter int CNT_WIDTH     = 32
);
    logic                              i_valid;
    logic                              o_ready_in;
    logic                              i_stationary;
    logic [NUM_PES-1:0]                i_pe_mask;
    logic [NUM_PES*IN_DATA_TYPE-1:0]   i_data_bus;
    logic                              i_clr_cnt;
    logic                              o_valid;
    logic                              i_ready_out;
    logic [NUM_PES-1:0]                o_pe_valid;
    logic [NUM_PES*OUT_DATA_TYPE-1:0]  o_data_bus;
    logic [NUM_PES-1:0]                o_stat_loaded;
    logic [CNT_WIDTH-1:0]              o_beat_cnt;

    modport master (
        output i_valid, i_stationary, i_pe_mask, i_data_bus, i_clr_cnt, i_ready_out,
        input  o_ready_in, o_valid, o_pe_valid, o_data_bus, o_stat_loaded, o_beat_cnt
    );

    modport slave (
        input  i_valid, i_stationary, i_pe_mask, i_data_bus, i_clr_cnt, i_ready_out,
        output o_ready_in, o_valid, o_pe_valid, o_data_bus, o_stat_loaded, o_beat_cnt
    );
endinterface

// File: rtl/mult_array_pipe.sv
// Stationary-operand multiplier array: NUM_PES lanes, streaming beat -> product vector in MULT_LATENCY cycles.
// One global stall: when the output is held (o_valid && !i_ready_out) every stage freezes and o_ready_in drops.
module mult_array_pipe #(
    parameter int IN_DATA_TYPE  = 8,
    parameter int OUT_DATA_TYPE = 24,
    parameter int NUM_PES       = 32,
    parameter int MULT_LATENCY  = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic              CLK,
    input  logic              rst,
    mult_array_pipe_if.slave  bus
);
    localparam int IN  = IN_DATA_TYPE;
    localparam int OUT = OUT_DATA_TYPE;

    logic [NUM_PES*IN-1:0]   r_stat;
    logic [NUM_PES-1:0]      r_stat_loaded;
    logic [CNT_WIDTH-1:0]    r_beat_cnt;
    logic [MULT_LATENCY-1:0] r_stg_vld;
    logic [NUM_PES-1:0]      r_stg_mask [MULT_LATENCY];
    logic [NUM_PES*OUT-1:0]  r_stg_data [MULT_LATENCY];

    logic                    w_adv;
    logic                    w_acc_strm;
    logic                    w_acc_stat;
    logic [NUM_PES*OUT-1:0]  w_prod_bus;

    assign w_adv      = !r_stg_vld[MULT_LATENCY-1] || bus.i_ready_out;
    assign w_acc_strm = bus.i_valid && w_adv && !bus.i_stationary;
    assign w_acc_stat = bus.i_valid && w_adv &&  bus.i_stationary;

    // Products are formed at acceptance so a later stationary load cannot affect a beat already taken.
    genvar g;
    generate
        for (g = 0; g < NUM_PES; g++) begin : g_lane
            logic signed [IN-1:0]   w_a;
            logic signed [IN-1:0]   w_b;
            logic signed [2*IN-1:0] w_full;
            logic        [OUT-1:0]  w_ext;

            assign w_a    = r_stat[g*IN +: IN];
            assign w_b    = bus.i_data_bus[g*IN +: IN];
            assign w_full = w_a * w_b;

            if (OUT <= 2*IN) begin : g_trunc
                assign w_ext = w_full[OUT-1:0];
            end else begin : g_sext
                assign w_ext = {{(OUT-2*IN){w_full[2*IN-1]}}, w_full};
            end

            assign w_prod_bus[g*OUT +: OUT] = bus.i_pe_mask[g] ? w_ext : '0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_stg_vld <= '0;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                r_stg_mask[s] <= '0;
                r_stg_data[s] <= '0;
            end
        end else if (w_adv) begin
            r_stg_vld[0]  <= w_acc_strm;
            r_stg_mask[0] <= w_acc_strm ? bus.i_pe_mask : '0;
            r_stg_data[0] <= w_acc_strm ? w_prod_bus : '0;
            for (int s = 1; s < MULT_LATENCY; s++) begin
                r_stg_vld[s]  <= r_stg_vld[s-1];
                r_stg_mask[s] <= r_stg_mask[s-1];
                r_stg_data[s] <= r_stg_data[s-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_stat        <= '0;
            r_stat_loaded <= '0;
        end else if (w_acc_stat) begin
            for (int i = 0; i < NUM_PES; i++) begin
                if (bus.i_pe_mask[i]) begin
                    r_stat[i*IN +: IN] <= bus.i_data_bus[i*IN +: IN];
                    r_stat_loaded[i]   <= 1'b1;
                end
            end
        end
    end

    // A clear coinciding with an accepted beat counts that beat.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (bus.i_clr_cnt) begin
            r_beat_cnt <= w_acc_strm ? CNT_WIDTH'(1) : '0;
        end else if (w_acc_strm) begin
            r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.o_ready_in    = w_adv;
    assign bus.o_valid       = r_stg_vld[MULT_LATENCY-1];
    assign bus.o_pe_valid    = r_stg_mask[MULT_LATENCY-1];
    assign bus.o_data_bus    = r_stg_data[MULT_LATENCY-1];
    assign bus.o_stat_loaded = r_stat_loaded;
    assign bus.o_beat_cnt    = r_beat_cnt;
endmodule

// File: tb/tb_mult_array_pipe.sv
// Directed bench: an 8-lane/24-bit/latency-2 array for the main function and a 4-lane/12-bit/latency-3/4-bit-counter
// array for truncation and counter wrap.
module tb_mult_array_pipe;
    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    mult_array_pipe_if #(.IN_DATA_TYPE(8), .OUT_DATA_TYPE(24), .NUM_PES(8), .CNT_WIDTH(32)) m ();
    mult_array_pipe_if #(.IN_DATA_TYPE(8), .OUT_DATA_TYPE(12), .NUM_PES(4), .CNT_WIDTH(4))  m2 ();

    mult_array_pipe #(.IN_DATA_TYPE(8), .OUT_DATA_TYPE(24), .NUM_PES(8), .MULT_LATENCY(2), .CNT_WIDTH(32))
        u_dut (.CLK(CLK), .rst(rst), .bus(m));
    mult_array_pipe #(.IN_DATA_TYPE(8), .OUT_DATA_TYPE(12), .NUM_PES(4), .MULT_LATENCY(3), .CNT_WIDTH(4))
        u_dut2 (.CLK(CLK), .rst(rst), .bus(m2));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] st;
        logic [31:0] dt;
        logic [3:0]  mask;
        logic [95:0] ex;
        logic [3:0]  pev;
    } vec_t;

    vec_t        vt [5];
    logic [95:0] sb_exp [4];

    function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [95:0] pk24(input int a, input int b, input int c, input int d);
        return {24'(d), 24'(c), 24'(b), 24'(a)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic vld, input logic st, input logic [7:0] mask, input logic [31:0] d);
        m.i_valid      = vld;
        m.i_stationary = st;
        m.i_pe_mask    = mask;
        m.i_data_bus   = {32'h0, d};
    endtask

    task automatic drv2(input logic vld, input logic st, input logic [3:0] mask, input logic [31:0] d);
        m2.i_valid      = vld;
        m2.i_stationary = st;
        m2.i_pe_mask    = mask;
        m2.i_data_bus   = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc, take, prev_stall;
        logic [191:0] held;
        int          sent, got;

        vt[0] = '{pk4(3, -2, 7, 0),         pk4(5, 5, -4, 9),        4'hF, pk24(15, -10, -28, 0),          4'hF};
        vt[1] = '{pk4(-128, -128, 127, 1),  pk4(-128, 127, 127, -1), 4'hF, pk24(16384, -16256, 16129, -1), 4'hF};
        vt[2] = '{pk4(10, 20, 30, 40),      pk4(1, 2, 3, 4),         4'h5, pk24(10, 0, 90, 0),             4'h5};
        vt[3] = '{pk4(1, 2, 3, 4),          pk4(9, 9, 9, 9),         4'h0, pk24(0, 0, 0, 0),               4'h0};
        vt[4] = '{pk4(-1, -1, 2, 100),      pk4(-1, 1, -3, -100),    4'hF, pk24(1, -1, -6, -10000),        4'hF};
        sb_exp[0] = pk24(2, 3, -1, 5);
        sb_exp[1] = pk24(4, 6, -2, 10);
        sb_exp[2] = pk24(6, 9, -3, 15);
        sb_exp[3] = pk24(8, 12, -4, 20);

        rst = 1'b1;
        drv(1'b0, 1'b0, 8'h00, 32'h0);
        m.i_clr_cnt = 1'b0;
        m.i_ready_out = 1'b1;
        drv2(1'b0, 1'b0, 4'h0, 32'h0);
        m2.i_clr_cnt = 1'b0;
        m2.i_ready_out = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid",  m.o_valid, 0);
        chk("rst_data",   m.o_data_bus, 0);
        chk("rst_pev",    m.o_pe_valid, 0);
        chk("rst_loaded", m.o_stat_loaded, 0);
        chk("rst_cnt",    m.o_beat_cnt, 0);
        chk("rst_rdy",    m.o_ready_in, 1);

        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 1'b1, 8'h0F, vt[k].st);
            tick();
            drv(1'b1, 1'b0, {4'h0, vt[k].mask}, vt[k].dt);
            tick();
            drv(1'b0, 1'b0, 8'h00, 32'h0);
            chk($sformatf("vec%0d_early", k), m.o_valid, 0);
            tick();
            chk($sformatf("vec%0d_valid", k), m.o_valid, 1);
            chk($sformatf("vec%0d_data", k),  m.o_data_bus, {96'h0, vt[k].ex});
            chk($sformatf("vec%0d_pev", k),   m.o_pe_valid, {4'h0, vt[k].pev});
            chk($sformatf("vec%0d_cnt", k),   m.o_beat_cnt, k + 1);
            tick();
        end

        // Four back-to-back beats with the output stalled for three cycles mid-burst.
        drv(1'b1, 1'b1, 8'h0F, pk4(2, 3, -1, 5));
        tick();
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            m.i_ready_out = !(c >= 3 && c <= 5);
            drv(sent < 4, 1'b0, 8'h0F, pk4(sent + 1, sent + 1, sent + 1, sent + 1));
            #1;
            if (m.o_valid && !m.i_ready_out) chk("stall_rdy", m.o_ready_in, 0);
            if (prev_stall) chk("stall_hold", m.o_data_bus, held);
            prev_stall = m.o_valid && !m.i_ready_out;
            held = m.o_data_bus;
            acc  = m.i_valid && m.o_ready_in;
            take = m.o_valid && m.i_ready_out;
            if (take) begin
                chk($sformatf("stall_order%0d", got), m.o_data_bus, {96'h0, sb_exp[got]});
                got++;
            end
            @(posedge CLK);
            #1;
            if (acc) sent++;
        end
        drv(1'b0, 1'b0, 8'h00, 32'h0);
        m.i_ready_out = 1'b1;
        chk("stall_got", got, 4);
        chk("stall_sent", sent, 4);
        tick();
        chk("stall_nodup", m.o_valid, 0);

        // Reset with beats in flight.
        drv(1'b1, 1'b0, 8'h0F, pk4(1, 1, 1, 1));
        tick();
        tick();
        drv(1'b0, 1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid",  m.o_valid, 0);
        chk("mrst_data",   m.o_data_bus, 0);
        chk("mrst_loaded", m.o_stat_loaded, 0);
        chk("mrst_cnt",    m.o_beat_cnt, 0);
        tick();
        tick();
        chk("mrst_quiet", m.o_valid, 0);

        drv(1'b1, 1'b0, 8'h0F, pk4(5, 5, 5, 5));
        tick();
        tick();
        drv(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        chk("statclr_valid", m.o_valid, 1);
        chk("statclr_data",  m.o_data_bus, 0);
        chk("statclr_pev",   m.o_pe_valid, 8'h0F);
        chk("cnt_two",       m.o_beat_cnt, 2);
        drv(1'b1, 1'b0, 8'h0F, pk4(5, 5, 5, 5));
        m.i_clr_cnt = 1'b1;
        tick();
        drv(1'b0, 1'b0, 8'h00, 32'h0);
        chk("clr_with_acc", m.o_beat_cnt, 1);
        tick();
        m.i_clr_cnt = 1'b0;
        chk("clr_alone", m.o_beat_cnt, 0);
        tick();

        // Partial stationary loads; the streaming beat immediately follows the lane-1 load.
        drv(1'b1, 1'b1, 8'h0D, pk4(4, 99, 6, 7));
        tick();
        chk("mask_loaded_d", m.o_stat_loaded, 8'h0D);
        drv(1'b1, 1'b1, 8'h02, pk4(55, 10, 55, 55));
        tick();
        chk("mask_loaded_f", m.o_stat_loaded, 8'h0F);
        drv(1'b1, 1'b0, 8'h0F, pk4(2, 2, 2, 2));
        tick();
        drv(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        chk("mask_valid", m.o_valid, 1);
        chk("mask_data",  m.o_data_bus, {96'h0, pk24(8, 20, 12, 14)});
        tick();

        // 12-bit truncation, latency 3, 4-bit counter wrap.
        drv2(1'b1, 1'b1, 4'h1, pk4(127, 0, 0, 0));
        tick();
        drv2(1'b1, 1'b0, 4'h1, pk4(127, 0, 0, 0));
        tick();
        drv2(1'b0, 1'b0, 4'h0, 32'h0);
        chk("t12_early1", m2.o_valid, 0);
        tick();
        chk("t12_early2", m2.o_valid, 0);
        tick();
        chk("t12_valid", m2.o_valid, 1);
        chk("t12_data",  m2.o_data_bus, 48'h000_000_000_F01);
        chk("t12_pev",   m2.o_pe_valid, 4'h1);
        drv2(1'b1, 1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 14; k++) tick();
        drv2(1'b0, 1'b0, 4'h0, 32'h0);
        chk("wrap_full", m2.o_beat_cnt, 4'hF);
        drv2(1'b1, 1'b0, 4'h0, 32'h0);
        tick();
        drv2(1'b0, 1'b0, 4'h0, 32'h0);
        chk("wrap_zero", m2.o_beat_cnt, 4'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
